uart_tx: RTL and testbench

Serial transmitter for the JUART link: accepts a parallel word through a valid/ready handshake and drives one UART frame on a single wire. The frame is one start bit (0), `data_len` data bits sent LSB first, and one stop bit (1), with each bit lasting `clk_div` clock cycles. It is the sending end of the line sampled by the UART receiver and uses the same `data_len`/`clk_div` parameterisation, so the two ends pair directly.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/uart_tx.sv | 93 +++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: one state encoding and default parameters for both link ends.
package uart_pkg;

  localparam int UART_DATA_LEN = 15;
  localparam int UART_CLK_DIV  = 100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RESTART
  } uart_state_t;

  // Counter width that stays at least one bit for degenerate (n==1) ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word-level handshake plus serial line of the UART transmitter.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_LEN = UART_DATA_LEN
);
  logic [DATA_LEN-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                tx_b;
  logic                tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_b,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_b,
    output tx_done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: wraps at clk_div-1, flags both the last cycle and the one before it.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o,
  output logic pre_tick_o
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt_q;

  assign tick_o     = en_i && (cnt_q == CNT_MAX);
  // Lets registered outputs line up with the final cycle of a bit period.
  assign pre_tick_o = en_i && (cnt_q == CNT_PRE);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_LEN bits LSB first, stop bit, CLK_DIV cycles per bit.
//   state   | meaning
//   S_IDLE  | line high, ready for a word
//   S_START | line low for one bit period
//   S_DATA  | shifting data bits out LSB first
//   S_STOP  | line high, tx_done in the last cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_LEN = UART_DATA_LEN,
  parameter int CLK_DIV  = UART_CLK_DIV
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);
  localparam int BW = cnt_width(DATA_LEN);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_LEN - 1);

  uart_state_t         state_q;
  logic [DATA_LEN-1:0] shift_q;
  logic [DATA_LEN-1:0] shift_d;
  logic [BW-1:0]       bit_q;
  logic                tx_b_q;
  logic                tx_done_q;
  logic                tick;
  logic                pre_tick;
  logic                accept;

  assign bus.tx_ready = (state_q == S_IDLE) && !rst;
  assign bus.tx_b     = tx_b_q;
  assign bus.tx_done  = tx_done_q;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign shift_d      = shift_q >> 1;

  uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == S_IDLE),
    .en_i      (state_q != S_IDLE),
    .tick_o    (tick),
    .pre_tick_o(pre_tick)
  );

  // tx_b_q is loaded with the value of the upcoming bit so the line changes on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      tx_b_q    <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shift_q <= bus.tx_data;
            tx_b_q  <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            bit_q   <= '0;
            tx_b_q  <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q <= shift_d;
            if (bit_q == BIT_MAX) begin
              tx_b_q  <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q  <= bit_q + BW'(1);
              tx_b_q <= shift_d[0];
            end
          end
        end
        S_STOP: begin
          if (pre_tick) tx_done_q <= 1'b1;
          if (tick) state_q <= S_IDLE;
        end
        default: begin
          tx_b_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover (8,4), (15,100) and (1,2) parameter sets.
module tb_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  uart_tx_if #(.DATA_LEN(8))  ifa ();
  uart_tx_if #(.DATA_LEN(15)) ifb ();
  uart_tx_if #(.DATA_LEN(1))  ifc ();

  logic [2:0]  vld;
  logic [7:0]  dat_a;
  logic [14:0] dat_b;
  logic [0:0]  dat_c;

  assign ifa.tx_valid = vld[0];
  assign ifa.tx_data  = dat_a;
  assign ifb.tx_valid = vld[1];
  assign ifb.tx_data  = dat_b;
  assign ifc.tx_valid = vld[2];
  assign ifc.tx_data  = dat_c;

  uart_tx #(.DATA_LEN(8),  .CLK_DIV(4))   dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  uart_tx #(.DATA_LEN(15), .CLK_DIV(100)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  uart_tx #(.DATA_LEN(1),  .CLK_DIV(2))   dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  // {tx_b, tx_ready, tx_done} per instance
  logic [2:0] mon [3];
  assign mon[0] = {ifa.tx_b, ifa.tx_ready, ifa.tx_done};
  assign mon[1] = {ifb.tx_b, ifb.tx_ready, ifb.tx_done};
  assign mon[2] = {ifc.tx_b, ifc.tx_ready, ifc.tx_done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int k, input int div, input int len, input logic [14:0] d);
    int idx;
    idx = k / div;
    if (idx == 0) return 1'b0;
    if (idx <= len) return d[idx-1];
    return 1'b1;
  endfunction

  // Call right after the acceptance edge; checks every cycle of the frame.
  task automatic frame_chk(input int w, input logic [14:0] d, input int len, input int div,
                           input string tag);
    int flen;
    flen = (len + 2) * div;
    for (int k = 0; k < flen; k++) begin
      @(negedge clk);
      chk($sformatf("%s_k%0d_line", tag, k), 32'(mon[w][2]), 32'(exp_bit(k, div, len, d)));
      chk($sformatf("%s_k%0d_ready", tag, k), 32'(mon[w][1]), 32'd0);
      chk($sformatf("%s_k%0d_done", tag, k), 32'(mon[w][0]), 32'(k == flen - 1));
    end
  endtask

  task automatic idle_chk(input int w, input string tag);
    @(negedge clk);
    chk({tag, "_line"}, 32'(mon[w][2]), 32'd1);
    chk({tag, "_ready"}, 32'(mon[w][1]), 32'd1);
    chk({tag, "_done"}, 32'(mon[w][0]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    vld   = '0;
    dat_a = '0;
    dat_b = '0;
    dat_c = '0;

    // reset for three edges, then release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_line_a", 32'(mon[0][2]), 32'd1);
      chk("rst_ready_a", 32'(mon[0][1]), 32'd0);
      chk("rst_done_a", 32'(mon[0][0]), 32'd0);
      chk("rst_line_b", 32'(mon[1][2]), 32'd1);
      chk("rst_line_c", 32'(mon[2][2]), 32'd1);
    end
    rst = 1'b0;
    #1;
    chk("rel_ready_a", 32'(mon[0][1]), 32'd1);
    idle_chk(0, "rel_a");

    // single frame 0xA5
    @(posedge clk); #1;
    dat_a = 8'hA5; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    frame_chk(0, 15'(8'hA5), 8, 4, "single");
    idle_chk(0, "single_after");

    // back-to-back with valid held: exactly one idle cycle between frames
    @(posedge clk); #1;
    dat_a = 8'h00; vld[0] = 1'b1;
    @(posedge clk); #1;
    dat_a = 8'hFF;
    frame_chk(0, 15'(8'h00), 8, 4, "b2b0");
    idle_chk(0, "b2b_gap");
    @(posedge clk); #1;
    vld[0] = 1'b0;
    frame_chk(0, 15'(8'hFF), 8, 4, "b2b1");
    idle_chk(0, "b2b_after");

    // data change and valid pulse mid-frame have no effect
    @(posedge clk); #1;
    dat_a = 8'hC3; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    fork
      frame_chk(0, 15'(8'hC3), 8, 4, "stab");
      begin
        repeat (9) @(posedge clk);
        #1 dat_a = 8'h3C; vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
      end
    join
    for (int i = 0; i < 4; i++) idle_chk(0, "stab_after");

    // reset during data bit 3 of 0x52, then reset coincident with valid
    @(posedge clk); #1;
    dat_a = 8'h52; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_k%0d_line", k), 32'(mon[0][2]), 32'(exp_bit(k, 4, 8, 15'(8'h52))));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_line", 32'(mon[0][2]), 32'd1);
    chk("rstmid_done", 32'(mon[0][0]), 32'd0);
    chk("rstmid_ready", 32'(mon[0][1]), 32'd0);
    dat_a = 8'hFF; vld[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; vld[0] = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      chk($sformatf("trunc_%0d_line", i), 32'(mon[0][2]), 32'd1);
      chk($sformatf("trunc_%0d_done", i), 32'(mon[0][0]), 32'd0);
      chk($sformatf("trunc_%0d_ready", i), 32'(mon[0][1]), 32'd1);
    end
    @(posedge clk); #1;
    dat_a = 8'h96; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    frame_chk(0, 15'(8'h96), 8, 4, "postrst");
    idle_chk(0, "postrst_after");

    // 15 data bits, 100 cycles per bit: 1700-cycle frame
    @(posedge clk); #1;
    dat_b = 15'h2A5C; vld[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    frame_chk(1, 15'h2A5C, 15, 100, "p15");
    idle_chk(1, "p15_after");

    // 1 data bit, 2 cycles per bit: 6-cycle frames
    @(posedge clk); #1;
    dat_c = 1'b1; vld[2] = 1'b1;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    frame_chk(2, 15'(1), 1, 2, "p1a");
    idle_chk(2, "p1a_after");
    @(posedge clk); #1;
    dat_c = 1'b0; vld[2] = 1'b1;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    frame_chk(2, 15'(0), 1, 2, "p1b");
    idle_chk(2, "p1b_after");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
